mul_share_arbiter: RTL and testbench

Shares one pipelined unsigned 6x6 multiplier among NREQ requesters with valid/ready handshakes. A round-robin arbiter issues at most one operation per cycle and tags it with the requester index. Each result returns to a per-requester response slot. It sits between the operand sources (switch/IO decode, systolic cells) and the single shared multiply resource.

---
 rtl/mul_share_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mul_share_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// Shares one pipelined unsigned AW x BW multiplier among NREQ requesters, with round-robin issue of at most one op per cycle.
// Latency: an op granted in cycle t shows rsp_valid[tag] from cycle t+MUL_LAT; aggregate throughput is one op per cycle.
// Backpressure: one op in flight per requester; a held response blocks only that requester, and the pipeline never stalls.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   per-requester issue handshake; req_ready is one-hot or zero
//   req_a, req_b          packed operands, requester i at [i*AW +: AW] / [i*BW +: BW]
//   rsp_valid/rsp_ready   per-requester result handshake
//   rsp_data              packed products, requester i at [i*(AW+BW) +: AW+BW]
//   busy                  any requester has an op pending
//
// Build option: define MULARB_PRIO_EN to give requester 0 fixed priority over the round-robin.
module mul_share_arbiter #(
   parameter int NREQ    = 4,
   parameter int AW      = 6,
   parameter int BW      = 6,
   parameter int MUL_LAT = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*AW-1:0]       req_a,
   input  logic [NREQ*BW-1:0]       req_b,
   output logic [NREQ-1:0]          rsp_valid,
   input  logic [NREQ-1:0]          rsp_ready,
   output logic [NREQ*(AW+BW)-1:0]  rsp_data,
   output logic                     busy
);

   localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PRW = AW + BW;

   logic [NREQ-1:0]      pend_q, pend_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic [NREQ-1:0]      rsp_valid_q, rsp_valid_d;
   logic [NREQ-1:0]      rsp_hs_q, rsp_hs_d;
   logic [NREQ*PRW-1:0]  rsp_data_q, rsp_data_d;

   logic [NREQ-1:0]      elig;
   logic [NREQ-1:0]      elig_rr;
   logic [PW-1:0]        srch_idx;
   logic                 grant_vld;
   logic [PW-1:0]        grant_idx;
   logic [AW-1:0]        op_a;
   logic [BW-1:0]        op_b;
   logic [PRW-1:0]       prod;

   logic                 exit_vld;
   logic [PW-1:0]        exit_tag;
   logic [PRW-1:0]       exit_prod;

   assign elig = req_valid & ~pend_q;

   // Grant search starts at ptr and wraps; the first eligible requester wins.
   always_comb begin
      elig_rr   = elig;
      srch_idx  = '0;
      grant_vld = 1'b0;
      grant_idx = '0;
      ptr_d     = ptr_q;
`ifdef MULARB_PRIO_EN
      // Requester 0 is served outside the rotation, so the rotation never lands on it.
      elig_rr[0] = 1'b0;
`endif
      for (int k = 0; k < NREQ; k++) begin
         srch_idx = PW'((int'(ptr_q) + k) % NREQ);
         if (!grant_vld && elig_rr[srch_idx]) begin
            grant_vld = 1'b1;
            grant_idx = srch_idx;
         end
      end
      if (grant_vld) begin
         ptr_d = PW'((int'(grant_idx) + 1) % NREQ);
      end
`ifdef MULARB_PRIO_EN
      if (grant_vld && ptr_d == '0) begin
         ptr_d = PW'(1);
      end
      if (elig[0]) begin
         grant_vld = 1'b1;
         grant_idx = '0;
         ptr_d     = ptr_q;
      end
`endif
   end

   always_comb begin
      req_ready = '0;
      if (grant_vld) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // Operand mux for the granted requester; the product is formed here and captured by the first stage.
   always_comb begin
      op_a = '0;
      op_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == PW'(i)) begin
            op_a = req_a[i*AW +: AW];
            op_b = req_b[i*BW +: BW];
         end
      end
      prod = PRW'(op_a) * PRW'(op_b);
   end

   // The response slot is the last of the MUL_LAT stages, so only MUL_LAT-1 intermediate registers exist.
   generate
      if (MUL_LAT == 1) begin : g_direct
         assign exit_vld  = grant_vld;
         assign exit_tag  = grant_idx;
         assign exit_prod = prod;
      end else begin : g_pipe
         localparam int NS = MUL_LAT - 1;
         logic [NS-1:0]  stg_vld_q, stg_vld_d;
         logic [PW-1:0]  stg_tag_q  [NS];
         logic [PW-1:0]  stg_tag_d  [NS];
         logic [PRW-1:0] stg_prod_q [NS];
         logic [PRW-1:0] stg_prod_d [NS];

         always_comb begin
            stg_vld_d     = '0;
            stg_vld_d[0]  = grant_vld;
            stg_tag_d[0]  = grant_idx;
            stg_prod_d[0] = prod;
            for (int s = 1; s < NS; s++) begin
               stg_vld_d[s]  = stg_vld_q[s-1];
               stg_tag_d[s]  = stg_tag_q[s-1];
               stg_prod_d[s] = stg_prod_q[s-1];
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               stg_vld_q <= '0;
               for (int s = 0; s < NS; s++) begin
                  stg_tag_q[s]  <= '0;
                  stg_prod_q[s] <= '0;
               end
            end else begin
               stg_vld_q <= stg_vld_d;
               for (int s = 0; s < NS; s++) begin
                  stg_tag_q[s]  <= stg_tag_d[s];
                  stg_prod_q[s] <= stg_prod_d[s];
               end
            end
         end

         assign exit_vld  = stg_vld_q[NS-1];
         assign exit_tag  = stg_tag_q[NS-1];
         assign exit_prod = stg_prod_q[NS-1];
      end
   endgenerate

   // Response slots and pend flags. pend drops one cycle after the handshake (via rsp_hs_q),
   // so a requester's next grant comes two cycles after it raises rsp_ready.
   always_comb begin
      rsp_valid_d = rsp_valid_q & ~rsp_ready;
      rsp_data_d  = rsp_data_q;
      rsp_hs_d    = rsp_valid_q & rsp_ready;
      pend_d      = pend_q & ~rsp_hs_q;
      if (grant_vld) begin
         pend_d[grant_idx] = 1'b1;
      end
      // A slot receiving a result is always empty: its requester was pending, so no new op could issue.
      for (int i = 0; i < NREQ; i++) begin
         if (exit_vld && exit_tag == PW'(i)) begin
            rsp_valid_d[i]              = 1'b1;
            rsp_data_d[i*PRW +: PRW]    = exit_prod;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q      <= '0;
         ptr_q       <= '0;
         rsp_valid_q <= '0;
         rsp_hs_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         pend_q      <= pend_d;
         ptr_q       <= ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_hs_q    <= rsp_hs_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = |pend_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: the stimulus pushes expected results into a scoreboard queue,
// and an independent monitor pops and compares them on every response handshake.
// Grants, busy and slot-holding behaviour are checked inline by the stimulus process.
module tb_mul_share_arbiter;

   localparam int NREQ    = 4;
   localparam int AW      = 6;
   localparam int BW      = 6;
   localparam int MUL_LAT = 2;
   localparam int PRW     = AW + BW;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*AW-1:0]   req_a;
   logic [NREQ*BW-1:0]   req_b;
   logic [NREQ-1:0]      rsp_valid;
   logic [NREQ-1:0]      rsp_ready;
   logic [NREQ*PRW-1:0]  rsp_data;
   logic                 busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int tag;
      int data;
      int vcyc;
   } exp_t;

   exp_t sb[$];

   mul_share_arbiter #(
      .NREQ(NREQ), .AW(AW), .BW(BW), .MUL_LAT(MUL_LAT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_a(req_a),
      .req_b(req_b),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data(rsp_data),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic set_op(input int i, input int a, input int b);
      req_a[i*AW +: AW] = 6'(a);
      req_b[i*BW +: BW] = 6'(b);
   endtask

   // Called mid-cycle: checks the grant and records the result expected MUL_LAT cycles later.
   task automatic grant(input string nm, input int idx, input int prod);
      exp_t e;
      chk(nm, int'(req_ready), 1 << idx);
      e.tag  = idx;
      e.data = prod;
      e.vcyc = cyc + MUL_LAT;
      sb.push_back(e);
   endtask

   // Monitor: track when each slot goes valid, and on each handshake match it against the scoreboard.
   logic [NREQ-1:0] prev_vld = '0;
   int              rise_cyc [NREQ];
   int              found;

   always @(negedge clk) begin
      for (int i = 0; i < NREQ; i++) begin
         if (rsp_valid[i] === 1'b1 && prev_vld[i] !== 1'b1) rise_cyc[i] = cyc;
         if (rsp_valid[i] === 1'b1 && rsp_ready[i] === 1'b1) begin
            found = -1;
            for (int j = 0; j < sb.size(); j++) begin
               if (sb[j].tag == i) begin
                  found = j;
                  break;
               end
            end
            if (found < 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp at cycle %0d: requester %0d data %0d, expected no response",
                        cyc, i, rsp_data[i*PRW +: PRW]);
            end else begin
               chk($sformatf("rsp_data_%0d", i), int'(rsp_data[i*PRW +: PRW]), sb[found].data);
               chk($sformatf("rsp_latency_%0d", i), rise_cyc[i], sb[found].vcyc);
               sb.delete(found);
            end
         end
         prev_vld[i] = rsp_valid[i];
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog at cycle %0d: simulation did not finish, expected completion", cyc);
      $fatal(1);
   end

   int s2_prod [4] = '{2, 12, 30, 56};
   int s2_a    [4] = '{1, 3, 5, 7};
   int s2_b    [4] = '{2, 4, 6, 8};

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      rsp_ready = '0;
      req_a     = '0;
      req_b     = '0;
      repeat (3) tick();
      mid();
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_rsp_data_nonzero", (rsp_data == '0) ? 0 : 1, 0);
      chk("rst_req_ready", int'(req_ready), 0);

      // Single op on requester 2: 63*63.
      tick();
      reset     = 1'b0;
      rsp_ready = 4'b1111;
      set_op(2, 63, 63);
      req_valid = 4'b0100;
      mid();
      grant("s1_grant", 2, 3969);
      tick();
      req_valid = '0;
      mid();
      chk("s1_busy", int'(busy), 1);
      chk("s1_rsp_early", int'(rsp_valid), 0);
      tick();
      mid();
      chk("s1_rsp_valid", int'(rsp_valid), 4'b0100);
      chk("s1_rsp_data", int'(rsp_data[2*PRW +: PRW]), 3969);
      tick();
      mid();
      chk("s1_rsp_clear", int'(rsp_valid), 0);
      tick();
      mid();
      chk("s1_busy_clear", int'(busy), 0);

      // All four requesters from a fresh pointer: grants 0,1,2,3 back to back.
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 0; k < NREQ; k++) set_op(k, s2_a[k], s2_b[k]);
      req_valid = 4'b1111;
      for (int k = 0; k < NREQ; k++) begin
         if (k > 0) begin
            tick();
            req_valid[k-1] = 1'b0;
         end
         mid();
         grant($sformatf("s2_grant%0d", k), k, s2_prod[k]);
      end
      tick();
      req_valid = '0;
      mid();
      chk("s2_idle_ready", int'(req_ready), 0);
      repeat (4) tick();

      // Back-pressure on requester 1: response held, new request blocked until consumed.
      rsp_ready = 4'b1101;
      set_op(1, 9, 10);
      req_valid = 4'b0010;
      mid();
      grant("s3_grant", 1, 90);
      for (int k = 1; k <= 10; k++) begin
         tick();
         mid();
         chk("s3_ready_held", int'(req_ready), 0);
         if (k >= 2) begin
            chk("s3_rsp_valid", int'(rsp_valid[1]), 1);
            chk("s3_rsp_data", int'(rsp_data[1*PRW +: PRW]), 90);
         end
      end
      tick();
      rsp_ready = 4'b1111;
      mid();
      chk("s3_ready_hs", int'(req_ready), 0);
      tick();
      mid();
      chk("s3_ready_after1", int'(req_ready), 0);
      chk("s3_rsp_cleared", int'(rsp_valid[1]), 0);
      chk("s3_data_kept", int'(rsp_data[1*PRW +: PRW]), 90);
      tick();
      mid();
      grant("s3_regrant", 1, 90);
      tick();
      req_valid = '0;
      repeat (4) tick();

      // Pointer now sits at 2; requesters 0 and 3 compete.
      set_op(0, 2, 3);
      set_op(3, 60, 61);
      req_valid = 4'b1001;
      mid();
`ifdef MULARB_PRIO_EN
      grant("s4_first", 0, 6);
      tick();
      req_valid = 4'b1000;
      mid();
      grant("s4_second", 3, 3660);
`else
      grant("s4_first", 3, 3660);
      tick();
      req_valid = 4'b0001;
      mid();
      grant("s4_second", 0, 6);
`endif
      tick();
      req_valid = '0;
      mid();
      chk("s4_idle_ready", int'(req_ready), 0);
      repeat (4) tick();

      // Reset one cycle after a grant: the op must vanish without a response.
      set_op(0, 5, 5);
      req_valid = 4'b0001;
      mid();
      chk("s5_grant", int'(req_ready), 1);
      tick();
      req_valid = '0;
      reset     = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         mid();
         chk("s5_rsp_valid", int'(rsp_valid), 0);
         chk("s5_busy", int'(busy), 0);
         tick();
      end

      // Requesters 0 and 1 continuously valid: 0 whenever eligible, 1 only while 0 is pending.
      set_op(0, 2, 2);
      set_op(1, 3, 3);
      req_valid = 4'b0011;
      for (int k = 0; k < 12; k++) begin
         mid();
         if (k % 4 == 0)      grant("s6_grant0", 0, 4);
         else if (k % 4 == 1) grant("s6_grant1", 1, 9);
         else                 chk("s6_no_grant", int'(req_ready), 0);
         tick();
      end
      req_valid = '0;
      repeat (5) tick();
      mid();
      chk("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
